leaf_user_bridge: RTL and testbench

Parametrised N-in/M-out bridge between a `leaf_interface` instance and an HLS user function using ap_vld/ap_ack port handshakes. Each channel gets a first-word-fall-through FIFO, so the user kernel and the BFT leaf never stall each other combinationally. A small control FSM sequences the kernel's ap_start/ap_ready/ap_done and reports completion only after all output FIFOs have drained to the leaf. It replaces the fixed 3×3 hand-wired page top with one generic block.

---
 rtl/leaf_user_bridge_if.sv | 55 +++++
 rtl/leaf_user_bridge.sv | 169 ++++++++++++++++
 tb/tb_leaf_user_bridge.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/leaf_user_bridge_if.sv
// Handshake bundle of leaf_user_bridge: leaf-side links, kernel Input_*/Output_* ports and run control.
// slave is the bridge's view; master is the environment's (leaf, kernel and page top).
interface leaf_user_bridge_if #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 3,
  parameter int NUM_OUT_PORTS = 3
);
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user;
  logic [NUM_IN_PORTS-1:0]               vld_interface2user;
  logic [NUM_IN_PORTS-1:0]               ack_user2interface;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  user_in_data;
  logic [NUM_IN_PORTS-1:0]               user_in_vld;
  logic [NUM_IN_PORTS-1:0]               user_in_ack;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] user_out_data;
  logic [NUM_OUT_PORTS-1:0]              user_out_vld;
  logic [NUM_OUT_PORTS-1:0]              user_out_ack;
  logic                                  ap_start;
  logic                                  ap_done;
  logic                                  user_ap_start;
  logic                                  user_ap_ready;
  logic                                  user_ap_done;

  modport slave (
    input  dout_leaf_interface2user, vld_interface2user,
    output ack_user2interface,
    output din_leaf_user2interface, vld_user2interface,
    input  ack_interface2user,
    output user_in_data, user_in_vld,
    input  user_in_ack,
    input  user_out_data, user_out_vld,
    output user_out_ack,
    input  ap_start,
    output ap_done,
    output user_ap_start,
    input  user_ap_ready, user_ap_done
  );

  modport master (
    output dout_leaf_interface2user, vld_interface2user,
    input  ack_user2interface,
    input  din_leaf_user2interface, vld_user2interface,
    output ack_interface2user,
    input  user_in_data, user_in_vld,
    output user_in_ack,
    output user_out_data, user_out_vld,
    input  user_out_ack,
    output ap_start,
    input  ap_done,
    input  user_ap_start,
    output user_ap_ready, user_ap_done
  );
endinterface

// File: rtl/leaf_user_bridge.sv
// Generic N-in/M-out bridge between a BFT leaf and an HLS kernel: one FWFT FIFO per channel plus
// ap_start/ap_done sequencing. Define LEAF_BRIDGE_STATS_EN to add per-channel transfer counters.
module leaf_user_bridge #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 3,
  parameter int NUM_OUT_PORTS = 3,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  leaf_user_bridge_if.slave bus
`ifdef LEAF_BRIDGE_STATS_EN
  ,
  output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*16-1:0] stat_words
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [NUM_IN_PORTS-1:0]               in_push, in_pop, in_full, in_empty;
  logic [NUM_OUT_PORTS-1:0]              out_push, out_pop, out_full, out_empty;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_head;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] out_head;

  genvar gi;

  // Leaf -> kernel FIFOs; flags come only from the registered count so ack never loops through the kernel
  generate
    for (gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
      logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
      logic [CNT_W-1:0]        count_reg;

      assign in_full[gi]  = (count_reg == FULL_CNT);
      assign in_empty[gi] = (count_reg == '0);
      assign in_push[gi]  = bus.vld_interface2user[gi] & ~in_full[gi];
      assign in_pop[gi]   = bus.user_in_ack[gi] & ~in_empty[gi];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (in_push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (in_pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({in_push[gi], in_pop[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (in_push[gi]) mem[wr_ptr_reg] <= bus.dout_leaf_interface2user[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
      end

      assign in_head[gi*PAYLOAD_BITS +: PAYLOAD_BITS] = in_empty[gi] ? '0 : mem[rd_ptr_reg];
    end

    for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out
      logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
      logic [CNT_W-1:0]        count_reg;

      assign out_full[gi]  = (count_reg == FULL_CNT);
      assign out_empty[gi] = (count_reg == '0);
      assign out_push[gi]  = bus.user_out_vld[gi] & ~out_full[gi];
      assign out_pop[gi]   = bus.ack_interface2user[gi] & ~out_empty[gi];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (out_push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (out_pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({out_push[gi], out_pop[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (out_push[gi]) mem[wr_ptr_reg] <= bus.user_out_data[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
      end

      assign out_head[gi*PAYLOAD_BITS +: PAYLOAD_BITS] = out_empty[gi] ? '0 : mem[rd_ptr_reg];
    end
  endgenerate

  assign bus.ack_user2interface      = ~in_full;
  assign bus.user_in_vld             = ~in_empty;
  assign bus.user_in_data            = in_head;
  assign bus.user_out_ack            = ~out_full;
  assign bus.vld_user2interface      = ~out_empty;
  assign bus.din_leaf_user2interface = out_head;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DRAIN} state_t;

  state_t state_reg, state_next;
  logic   kernel_start, run_done, outs_empty;

  assign outs_empty = &out_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Completion is held back until every output word has been taken by the leaf
  always_comb begin
    state_next   = state_reg;
    kernel_start = 1'b0;
    run_done     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.ap_start) state_next = S_START;
      end
      S_START: begin
        kernel_start = 1'b1;
        if (bus.user_ap_ready) state_next = bus.user_ap_done ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (bus.user_ap_done) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (outs_empty) begin
          run_done   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.user_ap_start = kernel_start;
  assign bus.ap_done       = run_done;

`ifdef LEAF_BRIDGE_STATS_EN
  localparam int NUM_CH = NUM_IN_PORTS + NUM_OUT_PORTS;

  logic [NUM_CH-1:0] stat_xfer;
  logic              stats_clear;

  // Counts leaf-side transfers: inputs as accepted from the leaf, outputs as delivered to it
  assign stat_xfer   = {out_pop, in_push};
  assign stats_clear = (state_reg == S_IDLE) && bus.ap_start;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_stat
      logic [15:0] cnt_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                               cnt_reg <= '0;
        else if (stats_clear)                       cnt_reg <= '0;
        else if (stat_xfer[gi] && (cnt_reg != '1))  cnt_reg <= cnt_reg + 1'b1;
      end

      assign stat_words[gi*16 +: 16] = cnt_reg;
    end
  endgenerate
`endif
endmodule

// File: tb/tb_leaf_user_bridge.sv
// Self-checking bench for leaf_user_bridge: queue/flag reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic and control.
module tb_leaf_user_bridge;
  localparam int PB    = 32;
  localparam int NI    = 3;
  localparam int NO    = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  leaf_user_bridge_if #(.PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO)) bus ();

`ifdef LEAF_BRIDGE_STATS_EN
  logic [(NI+NO)*16-1:0] stat_words;
`endif

  leaf_user_bridge #(
    .PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef LEAF_BRIDGE_STATS_EN
    ,
    .stat_words(stat_words)
`endif
  );

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  // Reference model: per-channel word lists plus run-progress flags
  logic [PB-1:0] in_buf  [NI][DEPTH];
  logic [PB-1:0] out_buf [NO][DEPTH];
  int            in_n    [NI];
  int            out_n   [NO];
  bit            running, ready_seen, kdone;

  logic [NI-1:0]    e_iack, e_ivld;
  logic [NO-1:0]    e_oack, e_ovld;
  logic [NI*PB-1:0] e_idata;
  logic [NO*PB-1:0] e_odata;
  bit               e_start, e_done, all_empty;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NI; i++) in_n[i] = 0;
    for (int j = 0; j < NO; j++) out_n[j] = 0;
    running    = 1'b0;
    ready_seen = 1'b0;
    kdone      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: expected outputs from the model, then advance the model by this cycle's transfers
  initial begin
    forever begin
      @(negedge clk);
      if (checking && reset_n) begin
        all_empty = 1'b1;
        for (int i = 0; i < NI; i++) begin
          e_iack[i] = (in_n[i] < DEPTH);
          e_ivld[i] = (in_n[i] > 0);
          e_idata[i*PB +: PB] = (in_n[i] > 0) ? in_buf[i][0] : '0;
        end
        for (int j = 0; j < NO; j++) begin
          e_oack[j] = (out_n[j] < DEPTH);
          e_ovld[j] = (out_n[j] > 0);
          e_odata[j*PB +: PB] = (out_n[j] > 0) ? out_buf[j][0] : '0;
          if (out_n[j] > 0) all_empty = 1'b0;
        end
        e_start = running && !ready_seen && !kdone;
        e_done  = running && kdone && all_empty;

        chk("ack_user2interface", bus.ack_user2interface, e_iack);
        chk("user_in_vld", bus.user_in_vld, e_ivld);
        chk("user_in_data", bus.user_in_data, e_idata);
        chk("user_out_ack", bus.user_out_ack, e_oack);
        chk("vld_user2interface", bus.vld_user2interface, e_ovld);
        chk("din_leaf_user2interface", bus.din_leaf_user2interface, e_odata);
        chk("user_ap_start", bus.user_ap_start, e_start);
        chk("ap_done", bus.ap_done, e_done);

        for (int i = 0; i < NI; i++) begin
          bit push, pop;
          push = bus.vld_interface2user[i] && e_iack[i];
          pop  = e_ivld[i] && bus.user_in_ack[i];
          if (pop) begin
            for (int k = 0; k < DEPTH - 1; k++) in_buf[i][k] = in_buf[i][k+1];
            in_n[i]--;
          end
          if (push) begin
            in_buf[i][in_n[i]] = bus.dout_leaf_interface2user[i*PB +: PB];
            in_n[i]++;
          end
        end
        for (int j = 0; j < NO; j++) begin
          bit push, pop;
          push = bus.user_out_vld[j] && e_oack[j];
          pop  = e_ovld[j] && bus.ack_interface2user[j];
          if (pop) begin
            for (int k = 0; k < DEPTH - 1; k++) out_buf[j][k] = out_buf[j][k+1];
            out_n[j]--;
          end
          if (push) begin
            out_buf[j][out_n[j]] = bus.user_out_data[j*PB +: PB];
            out_n[j]++;
          end
        end

        if (!running) begin
          if (bus.ap_start) begin
            running    = 1'b1;
            ready_seen = 1'b0;
            kdone      = 1'b0;
          end
        end else if (e_done) begin
          running = 1'b0;
        end else begin
          if (!kdone && bus.user_ap_done && (ready_seen || (e_start && bus.user_ap_ready)))
            kdone = 1'b1;
          if (e_start && bus.user_ap_ready) ready_seen = 1'b1;
        end
      end
    end
  end

  task automatic drive_idle();
    bus.dout_leaf_interface2user = '0;
    bus.vld_interface2user       = '0;
    bus.ack_interface2user       = '0;
    bus.user_in_ack              = '0;
    bus.user_out_data            = '0;
    bus.user_out_vld             = '0;
    bus.ap_start                 = 1'b0;
    bus.user_ap_ready            = 1'b0;
    bus.user_ap_done             = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ack_in"},  bus.ack_user2interface, {NI{1'b1}});
    chk({tag, "_ack_out"}, bus.user_out_ack, {NO{1'b1}});
    chk({tag, "_vld_in"},  bus.user_in_vld, '0);
    chk({tag, "_vld_out"}, bus.vld_user2interface, '0);
    chk({tag, "_data_in"}, bus.user_in_data, '0);
    chk({tag, "_data_out"}, bus.din_leaf_user2interface, '0);
    chk({tag, "_start"},   bus.user_ap_start, 1'b0);
    chk({tag, "_done"},    bus.ap_done, 1'b0);
  endtask

  initial begin
    int acc, rcv, pulses, done_cycle, start_cnt;
    logic [PB-1:0] w;

    drive_idle();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    reset_n  = 1'b1;
    checking = 1'b1;
    tick();

    // Three words through in-channel 0, each visible one cycle after its push
    bus.user_in_ack = '1;
    bus.vld_interface2user = 3'b001;
    bus.dout_leaf_interface2user[31:0] = 32'h11;
    tick();
    bus.dout_leaf_interface2user[31:0] = 32'h22;
    chk("t1_word0", bus.user_in_data[31:0], 32'h11);
    chk("t1_vld0", bus.user_in_vld, 3'b001);
    tick();
    bus.dout_leaf_interface2user[31:0] = 32'h33;
    chk("t1_word1", bus.user_in_data[31:0], 32'h22);
    tick();
    bus.vld_interface2user = '0;
    chk("t1_word2", bus.user_in_data[31:0], 32'h33);
    chk("t1_vld2", bus.user_in_vld, 3'b001);
    tick();
    chk("t1_empty", bus.user_in_vld, 3'b000);
    $display("t1: in-channel 0 delivered 11 22 33");

    // Back-pressure: six words offered against a stalled kernel
    bus.user_in_ack = '0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      bus.vld_interface2user = (acc < 6) ? 3'b001 : 3'b000;
      bus.dout_leaf_interface2user[31:0] = 32'(acc + 1);
      if (bus.ack_user2interface[0] && acc < 6) acc++;
      tick();
    end
    chk("t2_accepted_while_stalled", 32'(acc), 32'd4);
    chk("t2_ack_dropped", bus.ack_user2interface[0], 1'b0);
    bus.user_in_ack = 3'b001;
    rcv = 0;
    for (int c = 0; c < 20; c++) begin
      bus.vld_interface2user = (acc < 6) ? 3'b001 : 3'b000;
      bus.dout_leaf_interface2user[31:0] = 32'(acc + 1);
      if (bus.ack_user2interface[0] && acc < 6) acc++;
      if (bus.user_in_vld[0]) begin
        w = bus.user_in_data[31:0];
        chk("t2_word_order", w, 32'(rcv + 1));
        $display("t2: received word %0d", w);
        rcv++;
      end
      tick();
    end
    chk("t2_received", 32'(rcv), 32'd6);
    chk("t2_sent", 32'(acc), 32'd6);
    drive_idle();
    tick();

    // Run whose completion waits for out-channel 1 to drain
    pulses = 0;
    done_cycle = -1;
    start_cnt = 0;
    for (int c = 0; c <= 30; c++) begin
      bus.ap_start      = (c == 0);
      bus.user_ap_ready = (c == 2);
      bus.user_ap_done  = (c == 10);
      bus.user_out_vld  = (c >= 3 && c <= 5) ? 3'b010 : 3'b000;
      bus.user_out_data[63:32] = 32'(32'hA0 + c);
      bus.ack_interface2user = (c >= 20) ? 3'b010 : 3'b000;
      if (bus.ap_done) begin
        pulses++;
        done_cycle = c;
      end
      if (bus.user_ap_start) start_cnt++;
      tick();
    end
    chk("t4_done_cycle", 32'(done_cycle), 32'd23);
    chk("t4_done_pulses", 32'(pulses), 32'd1);
    chk("t4_start_cycles", 32'(start_cnt), 32'd2);
    $display("t4: ap_done pulsed in cycle %0d", done_cycle);
    drive_idle();
    tick();

    // Asynchronous reset with two buffered words and the run in progress
    bus.vld_interface2user = 3'b001;
    bus.dout_leaf_interface2user[31:0] = 32'h55;
    bus.ap_start = 1'b1;
    tick();
    bus.dout_leaf_interface2user[31:0] = 32'h66;
    bus.ap_start = 1'b0;
    bus.user_ap_ready = 1'b1;
    tick();
    drive_idle();
    chk("t5_buffered_head", bus.user_in_data[31:0], 32'h55);
    chk("t5_running", bus.user_ap_start, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_values("t5_async");
    model_clear();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("t5_fifo_empty", bus.user_in_vld, '0);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    chk("t5_idle_restart", bus.user_ap_start, 1'b1);
    $display("t5: reset cleared FIFOs and FSM restarted from idle");

    // Random traffic and control on every channel
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NI; i++) begin
        bus.vld_interface2user[i] = ($urandom_range(0, 3) != 0);
        bus.dout_leaf_interface2user[i*PB +: PB] = $urandom;
        bus.user_in_ack[i] = ($urandom_range(0, 2) != 0);
      end
      for (int j = 0; j < NO; j++) begin
        bus.user_out_vld[j] = ($urandom_range(0, 2) != 0);
        bus.user_out_data[j*PB +: PB] = $urandom;
        bus.ack_interface2user[j] = ($urandom_range(0, 3) != 0);
      end
      bus.ap_start      = ($urandom_range(0, 3) == 0);
      bus.user_ap_ready = ($urandom_range(0, 3) == 0);
      bus.user_ap_done  = ($urandom_range(0, 4) == 0);
      tick();
    end
    drive_idle();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
